// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial adder sequencer: FSM state encodings
// and small helpers used by add_seq.
package add_seq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADD  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // The sequencer reports busy from the first ADD cycle through DONE.
   function automatic logic state_is_busy(input state_t s);
      return (s == ST_ADD) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/rc_adder8.sv
// Existing 8-bit ripple-carry adder datapath; one full-adder cell per bit with
// the carry chained from bit 0 to bit 7.
module rc_adder8 (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic       Cout,
   output logic [7:0] S
);

   logic [8:0] c;

   assign c[0] = Cin;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign S[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end

   assign Cout = c[8];

endmodule

// File: rtl/add_seq.sv
// Byte-serial NBYTES-wide adder built around one shared rc_adder8.
// Optional subtract mode is enabled by defining ADD_SEQ_SUB_EN.
module add_seq
   import add_seq_pkg::*;
#(
   parameter  int NBYTES = 4,
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         cin,
`ifdef ADD_SEQ_SUB_EN
   input  logic         sub,
`endif
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int           CW   = $clog2(NBYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   state_t         state;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [W-1:0]   res_reg;
   logic           carry;
   logic [CW-1:0]  count;

   logic [W-1:0]   b_load;
   logic           c_load;
   logic [7:0]     add_s;
   logic           add_co;

   // Subtraction is a + ~b + 1, so only the B operand and the initial carry change.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      b_load = b;
      c_load = cin;
`ifdef ADD_SEQ_SUB_EN
      if (sub) begin
         b_load = ~b;
         c_load = 1'b1;
      end
`endif
   end

   rc_adder8 u_adder (
      .A    (a_reg[7:0]),
      .B    (b_reg[7:0]),
      .Cin  (carry),
      .Cout (add_co),
      .S    (add_s)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         carry   <= 1'b0;
         count   <= '0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_reg <= a;
                  b_reg <= b_load;
                  carry <= c_load;
                  count <= '0;
                  state <= ST_ADD;
               end
            end
            ST_ADD: begin
               // Each byte sum enters at the top, so after NBYTES shifts byte 0 sits at the bottom.
               a_reg   <= a_reg >> 8;
               b_reg   <= b_reg >> 8;
               res_reg <= (res_reg >> 8) | (W'(add_s) << (W - 8));
               carry   <= add_co;
               count   <= count + CW'(1);
               if (count == LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               sum   <= res_reg;
               cout  <= carry;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = state_is_busy(state);

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq: a 4-byte and a 1-byte instance share clock and reset.
module tb_add_seq;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start4 = 1'b0;
   logic        cin4   = 1'b0;
   logic [31:0] a4     = '0;
   logic [31:0] b4     = '0;
   logic        busy4, done4, cout4;
   logic [31:0] sum4;

   logic        start1 = 1'b0;
   logic        cin1   = 1'b0;
   logic [7:0]  a1     = '0;
   logic [7:0]  b1     = '0;
   logic        busy1, done1, cout1;
   logic [7:0]  sum1;

`ifdef ADD_SEQ_SUB_EN
   logic        sub4 = 1'b0;
   logic        sub1 = 1'b0;
`endif

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q4[$];
   exp_t q1[$];

   add_seq #(.NBYTES(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .cin   (cin4),
`ifdef ADD_SEQ_SUB_EN
      .sub   (sub4),
`endif
      .a     (a4),
      .b     (b4),
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4)
   );

   add_seq #(.NBYTES(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .cin   (cin1),
`ifdef ADD_SEQ_SUB_EN
      .sub   (sub1),
`endif
      .a     (a1),
      .b     (b1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Start on the 4-byte unit; done is due NBYTES+1 edges after the sampling edge.
   task automatic start4_op(input bit wait_neg, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input bit track, input logic [31:0] es, input logic ec);
      exp_t e;
      if (wait_neg) @(negedge clk);
      start4 = 1'b1;
      a4     = a;
      b4     = b;
      cin4   = c;
      @(posedge clk);
      #1;
      if (track) begin
         e.sum  = es;
         e.cout = ec;
         e.cyc  = cyc + 5;
         q4.push_back(e);
      end
      start4 = 1'b0;
      a4     = $urandom;
      b4     = $urandom;
      cin4   = ~c;
   endtask

   task automatic start1_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic [7:0] es, input logic ec);
      exp_t e;
      @(negedge clk);
      start1 = 1'b1;
      a1     = a;
      b1     = b;
      cin1   = c;
      @(posedge clk);
      #1;
      e.sum  = {24'h0, es};
      e.cout = ec;
      e.cyc  = cyc + 2;
      q1.push_back(e);
      start1 = 1'b0;
      a1     = 8'($urandom);
      b1     = 8'($urandom);
      cin1   = ~c;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (q4.size() == 0 && q1.size() == 0) break;
         @(negedge clk);
      end
      check("drain_timeout", q4.size() + q1.size(), 0);
      @(negedge clk);
   endtask

   task automatic wait_done4();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done4) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_done4_timeout", 32'(seen), 1);
   endtask

   // Monitor: pops an expectation on every done, otherwise results must hold.
   initial begin
      exp_t        e;
      logic [31:0] h4s, h1s;
      logic        h4c, h1c;
      h4s = '0; h1s = '0; h4c = 1'b0; h1c = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            h4s = '0; h1s = '0; h4c = 1'b0; h1c = 1'b0;
         end else begin
            if (done4) begin
               if (q4.size() == 0) begin
                  check("done4_unexpected", 32'(done4), 0);
               end else begin
                  e = q4.pop_front();
                  check("sum4", sum4, e.sum);
                  check("cout4", 32'(cout4), 32'(e.cout));
                  check("latency4", cyc, e.cyc);
                  check("busy4_at_done", 32'(busy4), 0);
                  h4s = e.sum;
                  h4c = e.cout;
               end
            end else begin
               check("hold_sum4", sum4, h4s);
               check("hold_cout4", 32'(cout4), 32'(h4c));
            end
            if (done1) begin
               if (q1.size() == 0) begin
                  check("done1_unexpected", 32'(done1), 0);
               end else begin
                  e = q1.pop_front();
                  check("sum1", 32'(sum1), e.sum);
                  check("cout1", 32'(cout1), 32'(e.cout));
                  check("latency1", cyc, e.cyc);
                  h1s = e.sum;
                  h1c = e.cout;
               end
            end else begin
               check("hold_sum1", 32'(sum1), h1s);
               check("hold_cout1", 32'(cout1), 32'(h1c));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy4", 32'(busy4), 0);
      check("rst_done4", 32'(done4), 0);
      check("rst_sum4", sum4, 0);
      check("rst_cout4", 32'(cout4), 0);
      check("rst_sum1", 32'(sum1), 0);
      check("rst_busy1", 32'(busy1), 0);
      rst = 1'b0;

      // Carry ripples out of byte 0; wrap-around at full width.
      start4_op(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1, 32'h0000_0100, 1'b0);
      drain();
      start4_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h0000_0000, 1'b1);
      drain();

      // Starts while busy (ADD and DONE) are ignored.
      start4_op(1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1, 32'h0000_0003, 1'b0);
      @(negedge clk);
      start4 = 1'b1;
      a4     = 32'h0000_0005;
      b4     = 32'h0000_0005;
      repeat (5) @(negedge clk);
      start4 = 1'b0;
      drain();
      repeat (10) @(negedge clk);

      // Back-to-back: each new start lands on the edge that ends the done cycle.
      start4_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1, 32'h2345_678A, 1'b0);
      wait_done4();
      start4_op(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1, 32'h0100_0100, 1'b0);
      wait_done4();
      start4_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 32'hFFFF_FFFF, 1'b1);
      drain();

      // Reset in the second ADD cycle aborts without a done pulse.
      start4_op(1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 0, 32'h0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy4", 32'(busy4), 0);
      check("abort_done4", 32'(done4), 0);
      check("abort_sum4", sum4, 0);
      check("abort_cout4", 32'(cout4), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      start4_op(1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1, 32'hFFFF_FFFF, 1'b0);
      drain();

      // Single-byte instance.
      start1_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      drain();
      start1_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
      drain();

`ifdef ADD_SEQ_SUB_EN
      @(negedge clk);
      sub4 = 1'b1;
      start4_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1, 32'hFFFF_FFFE, 1'b0);
      drain();
      start4_op(0, 32'h0000_0007, 32'h0000_0005, 1'b0, 1, 32'h0000_0002, 1'b1);
      drain();
      sub4 = 1'b0;
      start4_op(0, 32'h0000_0007, 32'h0000_0005, 1'b0, 1, 32'h0000_000C, 1'b0);
      drain();
      sub1 = 1'b1;
      start1_op(8'h03, 8'h04, 1'b0, 8'hFF, 1'b0);
      drain();
      sub1 = 1'b0;
`endif

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
